// File: rtl/val2_pkg.sv
// Shared encodings for the operand-2 shifter pipeline: shift types, operand
// field positions, datapath modes and the rotate-amount wrapping helper.
package val2_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int OP_ROT_HI  = 11;
  localparam int OP_ROT_LO  = 8;
  localparam int OP_IMM8_HI = 7;
  localparam int OP_AMT_HI  = 11;
  localparam int OP_AMT_LO  = 7;
  localparam int OP_TYPE_HI = 6;
  localparam int OP_TYPE_LO = 5;
  localparam int OP_REGAMT  = 4;

  typedef enum logic [1:0] {
    MODE_LOS   = 2'd0,
    MODE_IMM   = 2'd1,
    MODE_SHIFT = 2'd2
  } mode_e;

  // Rotates are reduced mod w, but a nonzero multiple of w is kept as w so the
  // core can still tell "rotated a full turn" apart from "no rotation".
  function automatic logic [7:0] wrap_amount(input logic [7:0] raw, input int unsigned w);
    logic [7:0] m;
    m = raw & 8'(w - 1);
    if (raw == 8'd0) begin
      wrap_amount = 8'd0;
    end else if (m == 8'd0) begin
      wrap_amount = 8'(w);
    end else begin
      wrap_amount = m;
    end
  endfunction

endpackage

// File: rtl/val2_shift_core.sv
// Combinational shift/rotate unit: turns a decoded, range-limited request into
// the operand-2 value and the shifter carry-out.
module val2_shift_core
  import val2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                      mode_is_los_i,
  input  logic [1:0]                sh_type_i,
  input  logic                      reg_amt_i,
  input  logic [$clog2(DATA_W):0]   amt_i,
  input  logic [DATA_W-1:0]         rm_i,
  input  logic                      carry_i,
  output logic [DATA_W-1:0]         val2_o,
  output logic                      carry_o
);

  localparam int AW = $clog2(DATA_W) + 1;
  localparam logic [AW-1:0] W_A   = AW'(DATA_W);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  logic              msb_s;
  logic [DATA_W-1:0] sh_l_s, sh_r_s, asr_s, ror_s, pre_l_s, pre_r_s;

  assign msb_s   = rm_i[DATA_W-1];
  assign sh_l_s  = rm_i << amt_i;
  assign sh_r_s  = rm_i >> amt_i;
  assign asr_s   = $unsigned($signed(rm_i) >>> amt_i);
  assign ror_s   = (rm_i >> amt_i) | (rm_i << (W_A - amt_i));
  // One position short of the final shift, so the last bit out sits at an edge.
  assign pre_l_s = rm_i << (amt_i - ONE_A);
  assign pre_r_s = rm_i >> (amt_i - ONE_A);

  // Result and carry selection by mode, amount class and shift type.
  always_comb begin
    val2_o  = rm_i;
    carry_o = carry_i;
    if (mode_is_los_i || (reg_amt_i && amt_i == '0)) begin
      val2_o  = rm_i;
      carry_o = carry_i;
    end else if (amt_i == '0) begin
      case (sh_type_i)
        SH_LSL: begin val2_o = rm_i;                        carry_o = carry_i; end
        SH_LSR: begin val2_o = {DATA_W{1'b0}};              carry_o = msb_s;   end
        SH_ASR: begin val2_o = {DATA_W{msb_s}};             carry_o = msb_s;   end
        SH_ROR: begin val2_o = {carry_i, rm_i[DATA_W-1:1]}; carry_o = rm_i[0]; end
        default: begin val2_o = rm_i;                       carry_o = carry_i; end
      endcase
    end else begin
      case (sh_type_i)
        SH_LSL: begin
          if (amt_i < W_A) begin
            val2_o = sh_l_s;          carry_o = pre_l_s[DATA_W-1];
          end else if (amt_i == W_A) begin
            val2_o = {DATA_W{1'b0}};  carry_o = rm_i[0];
          end else begin
            val2_o = {DATA_W{1'b0}};  carry_o = 1'b0;
          end
        end
        SH_LSR: begin
          if (amt_i < W_A) begin
            val2_o = sh_r_s;          carry_o = pre_r_s[0];
          end else if (amt_i == W_A) begin
            val2_o = {DATA_W{1'b0}};  carry_o = msb_s;
          end else begin
            val2_o = {DATA_W{1'b0}};  carry_o = 1'b0;
          end
        end
        SH_ASR: begin
          if (amt_i < W_A) begin
            val2_o = asr_s;           carry_o = pre_r_s[0];
          end else begin
            val2_o = {DATA_W{msb_s}}; carry_o = msb_s;
          end
        end
        SH_ROR: begin
          if (amt_i < W_A) begin
            val2_o = ror_s;           carry_o = ror_s[DATA_W-1];
          end else begin
            val2_o = rm_i;            carry_o = msb_s;
          end
        end
        default: begin val2_o = rm_i; carry_o = carry_i; end
      endcase
    end
  end

endmodule

// File: rtl/val2_shift_pipe.sv
// Two-stage operand-2 pipeline: S1 decodes mode and a range-limited amount,
// S2 registers the shifter result. Both stages stall together on back-pressure.
module val2_shift_pipe
  import val2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [7:0]        val_rs,
  input  logic [11:0]       shift_operand,
  input  logic              los,
  input  logic              imm,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              shifter_carry
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int AW      = SHAMT_W + 1;

  logic              advance_s;
  logic [7:0]        raw_amt_s;
  mode_e             mode_d, s1_mode_q;
  logic [1:0]        type_d, s1_type_q;
  logic              reg_amt_d, s1_reg_amt_q;
  logic [AW-1:0]     amt_d, s1_amt_q;
  logic [DATA_W-1:0] rm_d, s1_rm_q;
  logic              s1_valid_q, s1_carry_q;
  logic              out_valid_q, carry_q;
  logic [DATA_W-1:0] val2_q;
  logic [DATA_W-1:0] core_val2_s;
  logic              core_carry_s;

  assign advance_s = !out_valid_q || out_ready;
  assign in_ready  = advance_s;

  // Decode the request into mode, shift type and an amount limited to 0..DATA_W+1.
  always_comb begin
    mode_d    = MODE_SHIFT;
    type_d    = shift_operand[OP_TYPE_HI:OP_TYPE_LO];
    reg_amt_d = shift_operand[OP_REGAMT];
    rm_d      = val_rm;
    amt_d     = AW'(0);
    raw_amt_s = shift_operand[OP_REGAMT] ? val_rs : {3'b000, shift_operand[OP_AMT_HI:OP_AMT_LO]};
    if (los) begin
      mode_d    = MODE_LOS;
      type_d    = SH_LSL;
      reg_amt_d = 1'b1;
      rm_d      = DATA_W'(shift_operand);
    end else if (imm) begin
      // Rotated immediate reuses the register-ROR path; zero rotation keeps carry_in.
      mode_d    = MODE_IMM;
      type_d    = SH_ROR;
      reg_amt_d = 1'b1;
      rm_d      = DATA_W'(shift_operand[OP_IMM8_HI:0]);
      amt_d     = AW'(wrap_amount({3'b000, shift_operand[OP_ROT_HI:OP_ROT_LO], 1'b0}, DATA_W));
    end else if (type_d == SH_ROR) begin
      amt_d     = AW'(wrap_amount(raw_amt_s, DATA_W));
    end else if (raw_amt_s > 8'(DATA_W + 1)) begin
      amt_d     = AW'(DATA_W + 1);
    end else begin
      amt_d     = AW'(raw_amt_s);
    end
  end

  val2_shift_core #(.DATA_W(DATA_W)) u_core (
    .mode_is_los_i (s1_mode_q == MODE_LOS),
    .sh_type_i     (s1_type_q),
    .reg_amt_i     (s1_reg_amt_q),
    .amt_i         (s1_amt_q),
    .rm_i          (s1_rm_q),
    .carry_i       (s1_carry_q),
    .val2_o        (core_val2_s),
    .carry_o       (core_carry_s)
  );

  // Pipeline registers; both stages hold while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= MODE_SHIFT;
      s1_type_q    <= 2'b00;
      s1_reg_amt_q <= 1'b0;
      s1_amt_q     <= '0;
      s1_rm_q      <= '0;
      s1_carry_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      val2_q       <= '0;
      carry_q      <= 1'b0;
    end else if (advance_s) begin
      s1_valid_q   <= in_valid;
      s1_mode_q    <= mode_d;
      s1_type_q    <= type_d;
      s1_reg_amt_q <= reg_amt_d;
      s1_amt_q     <= amt_d;
      s1_rm_q      <= rm_d;
      s1_carry_q   <= carry_in;
      out_valid_q  <= s1_valid_q;
      val2_q       <= core_val2_s;
      carry_q      <= core_carry_s;
    end
  end

  assign out_valid     = out_valid_q;
  assign val2          = val2_q;
  assign shifter_carry = carry_q;

endmodule
